scale_div_responder: RTL and testbench

SCALE_DIV_RESPONDER -- requirements
Module: scale_div_responder

---
 rtl/scale_div_responder.sv | 149 ++++++++++++++
 tb/tb_scale_div_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_div_responder.sv
// Multi-cycle unsigned divider for the scale-parameter generator.
// Radix-2 restoring division, one quotient bit per clock, with a held response.
module scale_div_responder #(
    parameter int NUMER_W = 32,
    parameter int DENOM_W = 16,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUMER_W-1:0] req_numer,
    input  logic [DENOM_W-1:0] req_denom,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMER_W-1:0] rsp_quot,
    output logic [DENOM_W-1:0] rsp_rem,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_div0,
    output logic               busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is held until transfer.

    localparam int CNT_W = (NUMER_W > 1) ? $clog2(NUMER_W) : 1;

    typedef enum logic [1:0] {
        S_Idle    = 2'd0,
        S_Iterate = 2'd1,
        S_Div0    = 2'd2,
        S_Respond = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [NUMER_W-1:0] r_nq;
    logic [DENOM_W:0]   r_rem;
    logic [DENOM_W-1:0] r_den;
    logic [TAG_W-1:0]   r_tag;
    logic               r_div0;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_last_iter;
    logic [DENOM_W:0]   w_shift;
    logic [DENOM_W:0]   w_den_ext;
    logic               w_ge;
    logic [DENOM_W:0]   w_sub;
    logic               w_unused_rem_msb;

    assign w_accept    = (r_state == S_Idle) && req_valid;
    assign w_rsp_hs    = (r_state == S_Respond) && rsp_ready;
    assign w_last_iter = (r_cnt == CNT_W'(NUMER_W - 1));

    // The partial remainder stays below the denominator between steps, so its
    // low DENOM_W bits plus the incoming numerator bit form the full shifted value.
    assign w_shift   = {r_rem[DENOM_W-1:0], r_nq[NUMER_W-1]};
    assign w_den_ext = {1'b0, r_den};
    assign w_ge      = (w_shift >= w_den_ext);
    assign w_sub     = w_shift - w_den_ext;

    assign w_unused_rem_msb = r_rem[DENOM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_Idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_Idle: begin
                if (w_accept) begin
                    w_next_state = (req_denom != '0) ? S_Iterate : S_Div0;
                end
            end
            S_Iterate: begin
                if (w_last_iter) begin
                    w_next_state = S_Respond;
                end
            end
            S_Div0: begin
                w_next_state = S_Respond;
            end
            S_Respond: begin
                if (w_rsp_hs) begin
                    w_next_state = S_Idle;
                end
            end
            default: begin
                w_next_state = S_Idle;
            end
        endcase
    end

    // r_nq holds the numerator on entry and shifts quotient bits in from the LSB,
    // so after the last step it holds the full quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nq   <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_tag  <= '0;
            r_div0 <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_Idle: begin
                    if (w_accept) begin
                        r_nq   <= req_numer;
                        r_den  <= req_denom;
                        r_tag  <= req_tag;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_div0 <= 1'b0;
                    end
                end
                S_Iterate: begin
                    r_nq  <= {r_nq[NUMER_W-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_Div0: begin
                    r_rem  <= {1'b0, r_nq[DENOM_W-1:0]};
                    r_nq   <= '1;
                    r_div0 <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_Idle);
    assign busy      = (r_state != S_Idle);
    assign rsp_valid = (r_state == S_Respond);
    assign rsp_quot  = r_nq;
    assign rsp_rem   = r_rem[DENOM_W-1:0];
    assign rsp_tag   = r_tag;
    assign rsp_div0  = r_div0;

endmodule

// File: tb/tb_scale_div_responder.sv
// Self-checking bench for scale_div_responder: directed scenarios plus a
// randomized regression against an integer-division reference model.
module tb_scale_div_responder;

  localparam int NW = 32;
  localparam int DW = 16;
  localparam int TW = 2;
  localparam int EW = NW + DW + TW + 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [NW-1:0] req_numer;
  logic [DW-1:0] req_denom;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [NW-1:0] rsp_quot;
  logic [DW-1:0] rsp_rem;
  logic [TW-1:0] rsp_tag;
  logic          rsp_div0;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  scale_div_responder #(.NUMER_W(NW), .DENOM_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_numer(req_numer), .req_denom(req_denom), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_tag(rsp_tag),
    .rsp_div0(rsp_div0), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain integer division, divide-by-zero convention
  function automatic logic [EW-1:0] model(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                          input logic [TW-1:0] t);
    logic [NW-1:0] q;
    logic [NW-1:0] r;
    if (d == '0) begin
      q = '1;
      r = n;
      return {q, r[DW-1:0], t, 1'b1};
    end
    q = n / NW'(d);
    r = n % NW'(d);
    return {q, r[DW-1:0], t, 1'b0};
  endfunction

  // driver: present one request, return at the negedge after the accepting edge
  task automatic start_req(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic [TW-1:0] t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL start_timeout req_ready=%b required=1", req_ready);
    end
    req_valid = 1'b1;
    req_numer = n;
    req_denom = d;
    req_tag   = t;
    exp_q.push_back(model(n, d, t));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_numer = $urandom();
    req_denom = DW'($urandom());
    req_tag   = TW'($urandom());
  endtask

  // wait for rsp_valid, counting edges since acceptance; req_* is scrambled meanwhile
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      req_valid = 1'($urandom_range(0, 1));
      req_numer = $urandom();
      req_denom = DW'($urandom());
      req_tag   = TW'($urandom());
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    if (lat >= 200) begin
      total++; bad++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
    end
  endtask

  // scoreboard: hold the response for 'hold' cycles, compare, then hand it off
  task automatic take_rsp(input int hold);
    logic [EW-1:0] first;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    req_valid = 1'b0;
    first = {rsp_quot, rsp_rem, rsp_tag, rsp_div0};
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'($urandom_range(0, 1));
      req_numer = $urandom();
      req_denom = DW'($urandom());
      @(negedge clk);
      got = {rsp_quot, rsp_rem, rsp_tag, rsp_div0};
      total++;
      if (got !== first || rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got=%h v=%b rdy=%b busy=%b required=%h v=1 rdy=0 busy=1",
                 i, got, rsp_valid, req_ready, busy, first);
      end
    end
    req_valid = 1'b0;
    if (exp_q.size() == 0) begin
      exp = '0;
      total++; bad++;
      $display("FAIL scoreboard_empty");
    end else begin
      exp = exp_q.pop_front();
    end
    got = {rsp_quot, rsp_rem, rsp_tag, rsp_div0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL result got quot=%h rem=%h tag=%h div0=%b required quot=%h rem=%h tag=%h div0=%b",
               got[EW-1 -: NW], got[DW+TW:TW+1], got[TW:1], got[0],
               exp[EW-1 -: NW], exp[DW+TW:TW+1], exp[TW:1], exp[0]);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_hs v=%b rdy=%b busy=%b required v=0 rdy=1 busy=0",
               rsp_valid, req_ready, busy);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if (rsp_valid !== 1'b0 || rsp_quot !== '0 || rsp_rem !== '0 || rsp_tag !== '0 ||
        rsp_div0 !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s v=%b q=%h r=%h t=%h d0=%b busy=%b rdy=%b required all 0, rdy=1",
               name, rsp_valid, rsp_quot, rsp_rem, rsp_tag, rsp_div0, busy, req_ready);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int lo, input int hi);
    total++;
    if (lat < lo || lat > hi) begin
      bad++;
      $display("FAIL %s latency=%0d required %0d..%0d", name, lat, lo, hi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_release");
  endtask

  task automatic test_basic();
    int lat;
    rsp_ready = 1'b1;
    start_req(32'd100, 16'd7, 2'd1);
    wait_rsp(lat);
    check_lat("basic_latency", lat, NW, NW);
    take_rsp(0);
  endtask

  task automatic test_reciprocal();
    int lat;
    start_req(32'h0001_0000, 16'h0003, 2'd2);
    wait_rsp(lat);
    check_lat("recip_latency", lat, NW, NW);
    take_rsp(1);
  endtask

  task automatic test_div0();
    int lat;
    start_req(32'h1234_5678, 16'h0000, 2'd3);
    wait_rsp(lat);
    check_lat("div0_latency", lat, 1, 2);
    take_rsp(0);
  endtask

  task automatic test_backpressure();
    int lat;
    start_req(32'd500, 16'd9, 2'd0);
    wait_rsp(lat);
    check_lat("bp_latency", lat, NW, NW);
    take_rsp(10);
  endtask

  task automatic test_reset_mid();
    int lat;
    start_req(32'd1000, 16'd3, 2'd2);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("reset_mid_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) lat++;
    end
    total++;
    if (lat != 0) begin
      bad++;
      $display("FAIL reset_mid_ghost rsp_valid_cycles=%0d required 0", lat);
    end
    start_req(32'd9, 16'd4, 2'd1);
    wait_rsp(lat);
    check_lat("post_reset_latency", lat, NW, NW);
    take_rsp(0);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_req($urandom(), DW'($urandom_range(1, 65535)), TW'(i));
      wait_rsp(lat);
      check_lat("b2b_latency", lat, NW, NW);
      take_rsp(0);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    for (int i = 0; i < 1000; i++) begin
      n = $urandom();
      d = DW'($urandom_range(0, 65535));
      case (i % 10)
        0: d = 16'h0000;
        1: d = 16'h0001;
        2: d = 16'hFFFF;
        3: n = 32'hFFFF_FFFF;
        4: n = 32'h0000_0000;
        5: d = DW'($urandom_range(1, 15));
        default: ;
      endcase
      start_req(n, d, TW'($urandom()));
      wait_rsp(lat);
      if (d == '0) check_lat("rand_div0_latency", lat, 1, 2);
      else         check_lat("rand_latency", lat, NW, NW);
      take_rsp($urandom_range(0, 2));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_numer = '0;
    req_denom = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_reciprocal();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
